// File: rtl/seq_multiplier_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package seq_mult_pkg;

    // Widest operand the magnitude helper has to handle.
    localparam int MAG_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Two's-complement magnitude. The caller truncates the result to its
    // operand width. For the most negative value, the truncated result is
    // 2^(W-1), which is the correct unsigned magnitude.
    function automatic logic [MAG_W-1:0] twos_mag(input logic [MAG_W-1:0] v, input logic neg);
        return neg ? (~v + MAG_W'(1)) : v;
    endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// Operand/product handshake bundle for the sequential multiplier.
interface seq_multiplier_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 is_signed;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   p;
    logic                 busy;

    modport slave (
        input  in_valid, a, b, is_signed, out_ready,
        output in_ready, out_valid, p, busy
    );

    modport master (
        output in_valid, a, b, is_signed, out_ready,
        input  in_ready, out_valid, p, busy
    );
endinterface

// File: rtl/seq_multiplier_add_shift_step.sv
// One shift-add iteration. The multiplicand is conditionally added into the
// upper WIDTH+1 bits of the accumulator, and the result is shifted right by one.
module add_shift_step #(
    parameter int WIDTH = 8
) (
    input  logic [2*WIDTH:0]  acc_i,
    input  logic [WIDTH-1:0]  mcand_i,
    input  logic              lsb_i,
    output logic [2*WIDTH:0]  acc_o
);
    logic [WIDTH:0]   hi_sum;
    logic [2*WIDTH:0] added;

    // Add the partial product into the upper bits, then shift it into place.
    always_comb begin
        hi_sum = acc_i[2*WIDTH:WIDTH] + (lsb_i ? {1'b0, mcand_i} : {(WIDTH+1){1'b0}});
        added  = {hi_sum, acc_i[WIDTH-1:0]};
        acc_o  = added >> 1;
    end
endmodule

// File: rtl/seq_multiplier.sv
// Sequential multiplier that processes one partial product per clock.
// Operands are multiplied as unsigned magnitudes, and the sign is applied
// to the final product.
module seq_multiplier
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic             clk,
    input logic             rst_n,
    seq_multiplier_if.slave bus
);
    localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int                ACC_W    = 2*WIDTH + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [ACC_W-1:0]   acc_q, acc_d, acc_next;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic               a_neg, b_neg;

    add_shift_step #(.WIDTH(WIDTH)) u_step (
        .acc_i   (acc_q),
        .mcand_i (mcand_q),
        .lsb_i   (mplier_q[0]),
        .acc_o   (acc_next)
    );

    // Next-state and datapath decode for the IDLE -> CALC -> DONE sequence.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        p_d      = p_q;
        a_neg    = bus.is_signed & bus.a[WIDTH-1];
        b_neg    = bus.is_signed & bus.b[WIDTH-1];

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    mcand_d  = WIDTH'(twos_mag(MAG_W'(bus.a), a_neg));
                    mplier_d = WIDTH'(twos_mag(MAG_W'(bus.b), b_neg));
                    neg_d    = a_neg ^ b_neg;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                acc_d    = acc_next;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    // The last step's result goes straight to the output register.
                    p_d     = neg_q ? -acc_next[2*WIDTH-1:0] : acc_next[2*WIDTH-1:0];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers. Reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            p_q      <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            p_q      <= p_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.p         = p_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier at WIDTH=8, plus an exhaustive WIDTH=4 sweep.
module tb_seq_multiplier;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    seq_multiplier_if #(.WIDTH(8)) bus8 ();
    seq_multiplier_if #(.WIDTH(4)) bus4 ();

    seq_multiplier #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    seq_multiplier #(.WIDTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One WIDTH=8 transaction, with optional DONE hold and ignored in_valid pulses.
    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic s, input int hold, input bit noise,
                        input logic [15:0] exp);
        int lat;
        logic [15:0] p0;
        @(posedge clk); #1;
        chk({tag, "_in_ready"}, 64'(bus8.in_ready), 64'd1);
        bus8.a = a; bus8.b = b; bus8.is_signed = s; bus8.in_valid = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0; bus8.a = ~a; bus8.b = ~b; bus8.is_signed = ~s;
        lat = 0;
        while (!bus8.out_valid && lat < 40) begin
            if (noise) begin
                bus8.in_valid = lat[0];
                bus8.a = 8'hFF; bus8.b = 8'hFF;
            end
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'd8);
        chk({tag, "_p"}, 64'(bus8.p), 64'(exp));
        p0 = bus8.p;
        for (int i = 0; i < hold; i++) begin
            if (noise) bus8.in_valid = i[0];
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, 64'(bus8.out_valid), 64'd1);
            chk({tag, "_hold_p"}, 64'(bus8.p), 64'(p0));
        end
        bus8.in_valid = 1'b0;
        bus8.out_ready = 1'b1;
        @(posedge clk); #1;
        bus8.out_ready = 1'b0;
        chk({tag, "_done_valid"}, 64'(bus8.out_valid), 64'd0);
        chk({tag, "_done_ready"}, 64'(bus8.in_ready), 64'd1);
        @(posedge clk); #1;
        chk({tag, "_idle_busy"}, 64'(bus8.busy), 64'd0);
    endtask

    // One WIDTH=4 transaction with random consumer backpressure.
    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic s,
                        input logic [7:0] exp);
        int lat;
        int k;
        bit done;
        @(posedge clk); #1;
        bus4.a = a; bus4.b = b; bus4.is_signed = s; bus4.in_valid = 1'b1;
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
        lat = 0;
        while (!bus4.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("w4_lat_%0d_%0d_%0d", s, a, b), 64'(lat), 64'd4);
        chk($sformatf("w4_p_%0d_%0d_%0d", s, a, b), 64'(bus4.p), 64'(exp));
        k = 0;
        done = 1'b0;
        while (!done && k < 30) begin
            bus4.out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            if (bus4.out_ready) done = 1'b1;
            k++;
        end
        bus4.out_ready = 1'b0;
        chk("w4_handshake_done", 64'(done), 64'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ea;
        int eb;
        int prod;
        logic [7:0] exp4;

        bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.is_signed = 1'b0; bus8.out_ready = 1'b0;
        bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.is_signed = 1'b0; bus4.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(bus8.in_ready), 64'd1);
        chk("rst_busy", 64'(bus8.busy), 64'd0);
        chk("rst_out_valid", 64'(bus8.out_valid), 64'd0);
        chk("rst_p", 64'(bus8.p), 64'd0);
        rst_n = 1'b1;

        run8("u13x11", 8'd13, 8'd11, 1'b0, 0, 1'b0, 16'h008F);
        run8("u255x255", 8'hFF, 8'hFF, 1'b0, 0, 1'b0, 16'hFE01);
        run8("s80x80", 8'h80, 8'h80, 1'b1, 0, 1'b0, 16'h4000);
        run8("sm3x5", 8'hFD, 8'h05, 1'b1, 0, 1'b0, 16'hFFF1);
        run8("s0xm7", 8'h00, 8'hF9, 1'b1, 0, 1'b0, 16'h0000);
        run8("s80x7F", 8'h80, 8'h7F, 1'b1, 0, 1'b0, 16'hC080);
        run8("hold_noise", 8'h12, 8'h34, 1'b0, 5, 1'b1, 16'h03A8);

        // Abort a transaction at cnt = 3 with an asynchronous reset.
        @(posedge clk); #1;
        bus8.a = 8'h55; bus8.b = 8'h33; bus8.is_signed = 1'b0; bus8.in_valid = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_busy_before", 64'(bus8.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", 64'(bus8.in_ready), 64'd1);
        chk("abort_busy", 64'(bus8.busy), 64'd0);
        chk("abort_out_valid", 64'(bus8.out_valid), 64'd0);
        chk("abort_p", 64'(bus8.p), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run8("after_abort_7x6", 8'd7, 8'd6, 1'b0, 0, 1'b0, 16'd42);

        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    ea = (s == 1 && a >= 8) ? a - 16 : a;
                    eb = (s == 1 && b >= 8) ? b - 16 : b;
                    prod = ea * eb;
                    exp4 = prod[7:0];
                    run4(4'(a), 4'(b), 1'(s), exp4);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
